// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter that shares the single register-bank write port among
// R requesters. It issues registered one-cycle writes and supports locked
// bursts, so one requester can keep the port for consecutive writes.
module reg_write_arbiter #(
  parameter int N = 4,
  parameter int R = 4,
  parameter int A = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [R-1:0]     req,
  input  logic [R-1:0]     lock,
  input  logic [R*A-1:0]   req_addr,
  input  logic [R*N-1:0]   req_data,
  output logic [R-1:0]     gnt,
  output logic             we,
  output logic [A-1:0]     waddr,
  output logic [N-1:0]     wdata,
  output logic             busy
);

  localparam int PW = (R > 1) ? $clog2(R) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   holder_q, holder_d;
  logic [R-1:0]    gnt_q, gnt_d;
  logic            we_q, we_d;
  logic [A-1:0]    waddr_q, waddr_d;
  logic [N-1:0]    wdata_q, wdata_d;

  logic            found;
  int              winIdx;
  int              holderIdx;

  // Find the first active request starting at ptr and wrapping around.
  always_comb begin
    found  = 1'b0;
    winIdx = 0;
    for (int i = 0; i < R; i++) begin
      int idx;
      idx = (int'(ptr_q) + i) % R;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winIdx = idx;
      end
    end
  end

  // Next-state, grant and write-port values for the coming cycle.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    holder_d  = holder_q;
    gnt_d     = '0;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    holderIdx = int'(holder_q);
    case (state_q)
      LOCKED: begin
        if (req[holderIdx]) begin
          gnt_d   = R'(1) << holderIdx;
          we_d    = 1'b1;
          waddr_d = req_addr[holderIdx*A +: A];
          wdata_d = req_data[holderIdx*N +: N];
          state_d = lock[holderIdx] ? LOCKED : GRANT;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        if (found) begin
          gnt_d    = R'(1) << winIdx;
          we_d     = 1'b1;
          waddr_d  = req_addr[winIdx*A +: A];
          wdata_d  = req_data[winIdx*N +: N];
          ptr_d    = PW'((winIdx + 1) % R);
          holder_d = PW'(winIdx);
          state_d  = lock[winIdx] ? LOCKED : GRANT;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      holder_q <= '0;
      gnt_q    <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      holder_q <= holder_d;
      gnt_q    <= gnt_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign gnt   = gnt_q;
  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign busy  = (state_q == LOCKED);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Testbench for reg_write_arbiter: directed scenarios with literal
// expectations, then randomized traffic compared against a behavioural model.
module tb_reg_write_arbiter;

  localparam int N = 4;
  localparam int R = 4;
  localparam int A = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [R-1:0]   req = '0;
  logic [R-1:0]   lock = '0;
  logic [R*A-1:0] req_addr = '0;
  logic [R*N-1:0] req_data = '0;
  logic [R-1:0]   gnt;
  logic           we;
  logic [A-1:0]   waddr;
  logic [N-1:0]   wdata;
  logic           busy;

  int checks = 0;
  int errors = 0;
  bit chkEn = 1'b0;

  // Behavioural model state: priority index, locked holder (-1 when none)
  // and the outputs expected for the current cycle.
  int             mPtr = 0;
  int             mHolder = -1;
  logic [R-1:0]   eGnt = '0;
  logic           eWe = 1'b0;
  logic [A-1:0]   eAddr = '0;
  logic [N-1:0]   eData = '0;
  logic           eBusy = 1'b0;

  logic [R*A-1:0] addrAll;
  logic [R*N-1:0] dataAll;

  reg_write_arbiter #(.N(N), .R(R), .A(A)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock),
    .req_addr(req_addr), .req_data(req_data),
    .gnt(gnt), .we(we), .waddr(waddr), .wdata(wdata), .busy(busy)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  function automatic logic [R*A-1:0] addrAt(input int i, input logic [A-1:0] v);
    logic [R*A-1:0] r;
    r = '0;
    r[i*A +: A] = v;
    return r;
  endfunction

  function automatic logic [R*N-1:0] dataAt(input int i, input logic [N-1:0] v);
    logic [R*N-1:0] r;
    r = '0;
    r[i*N +: N] = v;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [R-1:0] r, input logic [R-1:0] l,
                               input logic [R*A-1:0] ad, input logic [R*N-1:0] d);
    req      = r;
    lock     = l;
    req_addr = ad;
    req_data = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Literal expectations checked against both the DUT and the model.
  task automatic expectOut(input string tag, input logic [R-1:0] g, input logic w,
                           input logic [A-1:0] ad, input logic [N-1:0] d, input logic b);
    checkOutput({tag, " gnt"},   32'(gnt),   32'(g));
    checkOutput({tag, " we"},    32'(we),    32'(w));
    checkOutput({tag, " waddr"}, 32'(waddr), 32'(ad));
    checkOutput({tag, " wdata"}, 32'(wdata), 32'(d));
    checkOutput({tag, " busy"},  32'(busy),  32'(b));
    checkOutput({tag, " model gnt"}, 32'(eGnt), 32'(g));
    checkOutput({tag, " model we"},  32'(eWe),  32'(w));
  endtask

  // One arbitration step of the reference model, straight from the rules.
  task automatic modelStep();
    int w;
    if (mHolder >= 0) begin
      if (req[mHolder]) begin
        eGnt  = R'(1) << mHolder;
        eWe   = 1'b1;
        eAddr = req_addr[mHolder*A +: A];
        eData = req_data[mHolder*N +: N];
        if (!lock[mHolder]) mHolder = -1;
      end else begin
        eGnt    = '0;
        eWe     = 1'b0;
        mHolder = -1;
      end
    end else begin
      w = -1;
      for (int k = 0; k < R; k++) begin
        if (w < 0 && req[(mPtr + k) % R]) w = (mPtr + k) % R;
      end
      if (w >= 0) begin
        eGnt  = R'(1) << w;
        eWe   = 1'b1;
        eAddr = req_addr[w*A +: A];
        eData = req_data[w*N +: N];
        mPtr  = (w + 1) % R;
        if (lock[w]) mHolder = w;
      end else begin
        eGnt = '0;
        eWe  = 1'b0;
      end
    end
    eBusy = (mHolder >= 0);
  endtask

  // Advance the model on every clock edge, or clear it on reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mPtr    = 0;
      mHolder = -1;
      eGnt    = '0;
      eWe     = 1'b0;
      eAddr   = '0;
      eData   = '0;
      eBusy   = 1'b0;
    end else begin
      modelStep();
    end
  end

  // Compare every DUT output with the model mid-cycle.
  always @(negedge clk) begin
    if (chkEn) begin
      checkOutput("cycle gnt",   32'(gnt),   32'(eGnt));
      checkOutput("cycle we",    32'(we),    32'(eWe));
      checkOutput("cycle waddr", 32'(waddr), 32'(eAddr));
      checkOutput("cycle wdata", 32'(wdata), 32'(eData));
      checkOutput("cycle busy",  32'(busy),  32'(eBusy));
    end
  end

  initial begin
    addrAll = '0;
    dataAll = '0;
    for (int i = 0; i < R; i++) begin
      addrAll = addrAll | addrAt(i, A'(i));
      dataAll = dataAll | dataAt(i, N'(i + 8));
    end

    repeat (2) @(posedge clk);
    chkEn = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick();
    expectOut("reset", '0, 1'b0, '0, '0, 1'b0);

    // Single request, then hold of address and data.
    applyStimulus(4'b0100, '0, addrAt(2, 2'd3), dataAt(2, 4'hA));
    tick();
    expectOut("single", 4'b0100, 1'b1, 2'd3, 4'hA, 1'b0);
    applyStimulus('0, '0, '0, '0);
    tick();
    expectOut("single hold", '0, 1'b0, 2'd3, 4'hA, 1'b0);

    // Reset in the middle of a write cycle.
    applyStimulus(4'b0100, '0, addrAt(2, 2'd1), dataAt(2, 4'h5));
    tick();
    expectOut("pre reset", 4'b0100, 1'b1, 2'd1, 4'h5, 1'b0);
    #2 rst = 1'b1;
    #1 expectOut("async reset", '0, 1'b0, '0, '0, 1'b0);
    applyStimulus('0, '0, '0, '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      tick();
      expectOut("idle after reset", '0, 1'b0, '0, '0, 1'b0);
    end

    // Round robin with all requesters active.
    applyStimulus(4'b1111, '0, addrAll, dataAll);
    for (int k = 0; k < 5; k++) begin
      tick();
      expectOut("round robin", R'(1) << (k % R), 1'b1, A'(k % R), N'((k % R) + 8), 1'b0);
    end

    // Wrap and skip from ptr=3.
    applyStimulus(4'b0100, '0, addrAll, dataAll);
    tick();
    expectOut("skip setup", 4'b0100, 1'b1, 2'd2, 4'hA, 1'b0);
    applyStimulus(4'b0101, '0, addrAll, dataAll);
    tick();
    expectOut("wrap", 4'b0001, 1'b1, 2'd0, 4'h8, 1'b0);
    tick();
    expectOut("skip", 4'b0100, 1'b1, 2'd2, 4'hA, 1'b0);
    applyStimulus(4'b0001, '0, addrAll, dataAll);
    tick();
    expectOut("burst setup", 4'b0001, 1'b1, 2'd0, 4'h8, 1'b0);

    // Locked burst by requester 1, final write, then requester 3.
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(4'b1011, 4'b0010, addrAll, dataAt(1, N'(k)));
      tick();
      expectOut("locked burst", 4'b0010, 1'b1, 2'd1, N'(k), 1'b1);
    end
    applyStimulus(4'b1011, 4'b0000, addrAll, dataAt(1, 4'h4));
    tick();
    expectOut("burst final", 4'b0010, 1'b1, 2'd1, 4'h4, 1'b0);
    applyStimulus(4'b1011, 4'b0000, addrAll, dataAll);
    tick();
    expectOut("after burst", 4'b1000, 1'b1, 2'd3, 4'hB, 1'b0);

    // Lock abort: holder drops its request.
    applyStimulus(4'b0010, 4'b0010, addrAll, dataAll);
    tick();
    expectOut("abort lock", 4'b0010, 1'b1, 2'd1, 4'h9, 1'b1);
    applyStimulus(4'b0001, 4'b0010, addrAll, dataAll);
    tick();
    expectOut("abort drop", '0, 1'b0, 2'd1, 4'h9, 1'b0);
    tick();
    expectOut("abort next", 4'b0001, 1'b1, 2'd0, 4'h8, 1'b0);

    // Randomized traffic with occasional asynchronous reset pulses.
    for (int c = 0; c < 800; c++) begin
      applyStimulus(R'($urandom),
                    ($urandom_range(0, 3) != 0) ? R'($urandom) : '0,
                    (R*A)'($urandom),
                    (R*N)'($urandom));
      if ($urandom_range(0, 63) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
      tick();
    end

    applyStimulus('0, '0, '0, '0);
    tick();
    chkEn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Round-robin arbiter sharing one write port of the register bank among R requesters; the bank is built from param_reg instances plus enable muxing.
- Samples the requests each cycle and picks one winner.
- Drives registered write-enable, address and data into the bank.
- Supports locked bursts, so one requester can keep the port for consecutive cycles (e.g. multi-register writeback).

Parameters:
- N, 4, data width of each register (matches bank register width)
- R, 4, number of requesters (2..8)
- A, 2, register address width (bank holds 2^A registers)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-high reset
- req  input  R  request per requester, level
- lock  input  R  per-requester burst lock; only sampled while that requester holds the grant
- req_addr  input  R*A  packed addresses; requester i occupies bits [i*A +: A]
- req_data  input  R*N  packed data; requester i occupies bits [i*N +: N]
- gnt  output  R  one-hot grant, registered
- we  output  1  bank write enable, registered
- waddr  output  A  bank write address, registered
- wdata  output  N  bank write data, registered
- busy  output  1  high in LOCKED state

Behaviour:
- Reset is asynchronous and active-high. Reset values: gnt=0, we=0, waddr=0, wdata=0, busy=0, ptr=0, state=IDLE. Reset asserted mid-burst clears all of these immediately, without waiting for a clock edge.
- Internal round-robin pointer ptr is ceil(log2 R) bits wide and holds the index with highest priority.
- Arbitration searches req from ptr upward, wrapping modulo R (ptr, ptr+1, ..., R-1, 0, ...). First set bit wins.
- Latency: a request sampled at edge k produces gnt/we/waddr/wdata valid during cycle k..k+1. The bank writes at edge k+1.
- A write is exactly one cycle with we=1. gnt is one-hot, and it is nonzero only when we=1.
- States:
  - IDLE: no grant outstanding.
  - GRANT: single write issued this cycle.
  - LOCKED: winner retains the port.
- Transitions at each rising edge:
  - IDLE or GRANT, req==0: go to IDLE; gnt=0, we=0; waddr/wdata hold.
  - IDLE or GRANT, some req set: winner w; gnt=1<<w, we=1, waddr/wdata latched from w's slice; ptr=(w+1) mod R.
    - If lock[w]=1 at that edge: go to LOCKED, busy=1.
    - Else: go to GRANT.
  - LOCKED, holder's req=1 and lock=1: stay LOCKED; another write from the holder's current slice; gnt unchanged; ptr unchanged.
  - LOCKED, holder's req=1 and lock=0: final write from the holder; go to GRANT; busy=0.
  - LOCKED, holder's req=0: go to IDLE; we=0, gnt=0, busy=0. The holder's lock is ignored.
- Other requests are ignored while LOCKED; they are not queued.
- Fairness: a requester holding req continuously cannot win twice in a row while another request is pending. It may win back-to-back only if it is the sole requester.
- Deasserting req after sampling does not cancel a grant already issued.
- lock of non-winners is ignored.
- Register the holder index in LOCKED; do not re-derive it from gnt.

Test Plan:
- Reset then idle: rst=1 mid-cycle while we=1 -> gnt=0, we=0, waddr=0, wdata=0, busy=0 immediately. With req=0 after release, all stay 0.
- Single request: req=4'b0100, req_addr slice2=2'd3, req_data slice2=4'hA at edge k -> cycle after k: gnt=4'b0100, we=1, waddr=3, wdata=A. Next edge with req=0 -> we=0, gnt=0, waddr=3 and wdata=A held.
- Round-robin: req=4'b1111 held for 5 edges from reset -> gnt sequence 0001, 0010, 0100, 1000, 0001.
- Wrap and skip: ptr=3 (after granting requester 2), req=4'b0101 -> gnt=0001. Next edge with req=4'b0101 -> gnt=0100.
- Locked burst: requester 1 wins with lock=1 while req=4'b1011 for 3 edges; data 4'h1, 4'h2, 4'h3 -> three consecutive writes from requester 1, busy=1, gnt=0010 throughout. Then lock=0 gives a final write and busy=0. The next grant goes to requester 3 (ptr=2, req2=0).
- Lock abort: in LOCKED the holder drops req -> next cycle we=0, gnt=0, busy=0, state IDLE. A pending req=4'b0001 is granted on the following edge.
